fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 24-bit core. Owns the program counter and drives the 8-bit PC into the asynchronous-read instruction_memory. Captures the returned 24-bit instruction into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with flush, halt, and a saturating issued-instruction counter.

Parameters:
PC_W, 8, program counter width in bits; equals the instruction_memory address width.
INSTR_W, 24, instruction word width in bits.
RESET_PC, 8'h00, PC value loaded on reset.
CNT_W, 16, width of the issued-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard stall from decode; holds PC and IF/ID.
redirect_valid  input  1  taken branch or jump this cycle.
redirect_pc  input  PC_W  target PC for the redirect.
halt  input  1  halt request from decode; sticky until reset.
imem_pc  output  PC_W  address to instruction_memory; combinational copy of the PC register.
imem_instr  input  INSTR_W  instruction word returned by instruction_memory in the same cycle.
ifid_valid  output  1  IF/ID register holds a real instruction.
ifid_pc  output  PC_W  PC of the instruction held in IF/ID.
ifid_instr  output  INSTR_W  instruction held in IF/ID; NOP_INSTR when not valid.
halted  output  1  high in the HALTED state.
fetch_count  output  CNT_W  number of instructions issued into IF/ID; saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc = RESET_PC; state = BOOT.
  - ifid_valid = 0, ifid_pc = 0, ifid_instr = NOP_INSTR.
  - halted = 0; fetch_count = 0.
- imem_pc = pc, purely combinational. Read latency is 0 cycles; instruction-to-IF/ID latency is 1 cycle.
- State machine, fetch_state_t with states BOOT, RUN, HALTED:
  - BOOT: lasts exactly 1 cycle after reset deasserts. PC holds, ifid_valid = 0. Next state is RUN unconditionally; inputs are ignored.
  - RUN: actions in priority order, highest first:
    1. halt: go to HALTED. PC holds; ifid_valid <= 0; ifid_instr <= NOP_INSTR.
    2. redirect_valid: pc <= redirect_pc; ifid_valid <= 0; ifid_instr <= NOP_INSTR. Flushes the wrong-path word currently being fetched. Redirect overrides stall.
    3. stall: PC, IF/ID and fetch_count all hold.
    4. Otherwise: ifid_valid <= 1; ifid_pc <= pc; ifid_instr <= imem_instr; pc <= pc + 1; fetch_count increments.
  - HALTED: PC and IF/ID frozen with ifid_valid = 0; halted = 1. stall, redirect and halt are ignored. Exit only via reset.
- Width and arithmetic rules:
  - PC increment is modulo 2^PC_W: 8'hFF wraps to 8'h00 with no flag.
  - fetch_count saturates at all-ones and never wraps.
  - redirect_pc is used as given; there is no alignment check.
- Simultaneous events:
  - halt + redirect: halt wins; the redirect is dropped.
  - redirect + stall: redirect wins.
  - Redirect to the current PC: still flushes, so one bubble results.
- No combinational path from stall, redirect or halt to any output except through registers. imem_pc is the registered PC.

Decomposition:
- Shared cpu_pkg holds:
  - PC_W = 8 and INSTR_W = 24.
  - NOP_INSTR = 24'h000000.
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - The ifid_t packed struct {valid, pc, instr}, which the decode stage reuses.
- One natural sub-module: ifid_reg. It is the IF/ID pipeline register with load, hold and flush controls and async reset. fetch_stage instantiates it and keeps the PC, the FSM and the counter.
- instruction_memory stays external and is wired only at the core top level.

Test Plan:
1. Reset, then release with no stall, using the existing 8-entry instruction_memory image → BOOT cycle with ifid_valid=0. Then ifid_pc runs 00,01,...,07 on consecutive cycles with ifid_instr matching memory words 0–7. fetch_count=8 after cycle 9.
2. Stall held 3 cycles while pc=8'h03 → imem_pc stays 03, IF/ID holds pc 02, fetch_count unchanged. On release, the next issue is pc 03.
3. At pc=8'h05, pulse redirect_valid=1 with redirect_pc=8'h01, stall=1 in the same cycle → next cycle ifid_valid=0, imem_pc=01. The following cycle gives ifid_pc=01.
4. Force pc to 8'hFE via redirect, then run freely → ifid_pc sequence FE, FF, 00, 01; no glitch on valid.
5. halt and redirect asserted together at pc=8'h04 → halted=1, imem_pc stays 04, ifid_valid=0 for 10 cycles regardless of inputs. Asserting reset mid-HALTED returns pc=00 and halted=0 asynchronously, before the next clock edge.
6. Drive fetch_count to 16'hFFFF by preloading the counter in the bench, then issue one more instruction → it stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 24-bit core: widths, the NOP encoding, the fetch FSM
// state type and the IF/ID pipeline record that the decode stage also consumes.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 24;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 24'h000000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, otherwise it holds. A flush keeps the
// stale PC but clears valid and forces the instruction word to NOP.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output ifid_t              q
);

  // NOTE: registers update with <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= '{valid: 1'b1, pc: pc, instr: instr};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/HALTED sequencer, issues
// words from the asynchronous instruction memory into IF/ID, counts issued words.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ifid_valid,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ifid_load, ifid_flush, cnt_inc;
  ifid_t              ifid_q;

  // Priority inside RUN is halt > redirect > stall > issue; the other states ignore inputs.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d    = HALTED;
          ifid_flush = 1'b1;
        end else if (redirect_valid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          pc_d      = pc_q + 1'b1;
          ifid_load = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Saturating issue counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .pc    (pc_q),
    .instr (imem_instr),
    .q     (ifid_q)
  );

  assign imem_pc     = pc_q;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_instr  = ifid_q.instr;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule
